capture_dump_ctrl: RTL



---
 rtl/capture_dump_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/capture_dump_ctrl.sv
// Frame capture buffer with length-prefixed UART dump, driven by save/output trigger pulses.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after each dump.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a save or output trigger
// ARMED    | byte_cnt/overflow cleared, waiting for a start-of-frame byte
// CAPTURE  | writing frame bytes until end-of-frame or buffer full
// HDR_HI   | presenting count[15:8]
// HDR_LO   | presenting count[7:0], buffer address 0 read issued
// DATA     | presenting buffer bytes 0..byte_cnt-1
// CSUM     | presenting XOR of all bytes sent (checksum build only)
module capture_dump_ctrl #(
  parameter int DEPTH = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       trigger_save_data,
  input  logic       trigger_output_data,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic [2:0] state_dbg,
  output logic       overflow
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HDR_HI  = 3'd3,
    S_HDR_LO  = 3'd4,
    S_DATA    = 3'd5,
    S_CSUM    = 3'd6
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  byte_cnt, byte_cnt_nx;
  logic [CNT_W-1:0]  ptr, ptr_nx;
  logic [CNT_W-1:0]  ptr_inc;
  logic              overflow_nx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_q;
  logic [15:0]       cnt16;
  logic              tx_fire;
  logic              tx_valid_nx;

  logic [7:0] mem [DEPTH];

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum;
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_IDLE;
`endif

  assign cnt16   = 16'(byte_cnt);
  assign tx_fire = tx_valid && tx_ready;
  assign ptr_inc = ptr + 1'b1;

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    overflow_nx = overflow;
    ptr_nx      = ptr;
    wr_en       = 1'b0;
    wr_addr     = byte_cnt[ADDR_W-1:0];
    rd_en       = 1'b0;
    rd_addr     = ptr_inc[ADDR_W-1:0];
    case (state)
      S_IDLE: begin
        if (trigger_save_data) begin
          state_nx    = S_ARMED;
          byte_cnt_nx = '0;
          overflow_nx = 1'b0;
        end else if (trigger_output_data) begin
          state_nx = S_HDR_HI;
        end
      end
      S_ARMED: begin
        if (in_valid && in_sof) begin
          wr_en       = 1'b1;
          wr_addr     = '0;
          byte_cnt_nx = CNT_W'(1);
          state_nx    = in_eof ? S_IDLE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_valid) begin
          wr_en       = 1'b1;
          byte_cnt_nx = byte_cnt + 1'b1;
          // Filling the last slot always flags overflow, even if that byte carried eof.
          if (byte_cnt == CNT_W'(DEPTH - 1)) begin
            overflow_nx = 1'b1;
            state_nx    = S_IDLE;
          end else if (in_eof) begin
            state_nx = S_IDLE;
          end
        end
      end
      S_HDR_HI: begin
        if (tx_fire) state_nx = S_HDR_LO;
      end
      S_HDR_LO: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        ptr_nx  = '0;
        if (tx_fire) state_nx = (byte_cnt == '0) ? S_AFTER_DATA : S_DATA;
      end
      S_DATA: begin
        if (tx_fire) begin
          if (ptr_inc == byte_cnt) begin
            state_nx = S_AFTER_DATA;
          end else begin
            ptr_nx = ptr_inc;
            rd_en  = 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (tx_fire) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign tx_valid_nx = (state_nx == S_HDR_HI) || (state_nx == S_HDR_LO) ||
                       (state_nx == S_DATA)   || (state_nx == S_CSUM);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      overflow <= 1'b0;
      ptr      <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      byte_cnt <= byte_cnt_nx;
      overflow <= overflow_nx;
      ptr      <= ptr_nx;
      tx_valid <= tx_valid_nx;
    end
  end

  // Read data only changes on a prefetch, so it stays stable through tx stalls.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == S_IDLE) begin
      csum <= '0;
    end else if (tx_fire) begin
      csum <= csum ^ tx_data;
    end
  end
`endif

  always_comb begin
    tx_data = '0;
    case (state)
      S_HDR_HI: tx_data = cnt16[15:8];
      S_HDR_LO: tx_data = cnt16[7:0];
      S_DATA:   tx_data = rd_q;
`ifdef DUMP_CHECKSUM_EN
      S_CSUM:   tx_data = csum;
`endif
      default:  tx_data = '0;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
